memory_arbiter_fsm: RTL and testbench
=====================================

Name: memory_arbiter_fsm

Overview:
- Sequential arbiter between the per-core cache block (instruction and data request channels) and the single-ported RAM model.
- Serialises instruction fetches and data loads/stores onto one RAM port.
- Data has priority, with a starvation guard for instruction fetches.
- Generates per-channel wait signals and a per-access timeout/error flag.

Parameters:
- TIMEOUT, 64, max cycles in a serve state without ramstate==ACCESS before aborting to error.
- STARVE_LIMIT, 4, consecutive completed data accesses with iREN pending before instruction gets forced priority.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous reset, active-high (asserted when 1, despite the name)
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- iwait  out  1  instruction not complete this cycle
- dwait  out  1  data not complete this cycle
- iload  out  32  instruction read data
- dload  out  32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- arb_err  out  1  sticky error flag (RAM ERROR or timeout)

Behaviour:
- States: IDLE, DSERV, ISERV, ERR. Reset enters IDLE.
- Registers cleared at reset: dstreak counter, timeout counter, arb_err.
- Output values while reset is held: iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, arb_err=0.
- IDLE:
  - No RAM enables; both waits high.
  - Next state DSERV if (dREN|dWEN) and not starve; ISERV if iREN.
  - starve = (dstreak==STARVE_LIMIT) & iREN. When starve is true, ISERV wins.
- DSERV:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. Write wins if both requests are high.
  - ramstate==ACCESS: dwait=0 combinationally that cycle; dload=ramload (read) else 0; next state IDLE.
  - dstreak updates on completion: +1 if iREN is high, saturating at STARVE_LIMIT; else cleared.
- ISERV:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
  - ramstate==ACCESS: iwait=0, iload=ramload, dstreak cleared; next state IDLE.
- Wait signals:
  - The non-granted channel's wait stays 1.
  - A granted channel's wait is 1 in every cycle except its completion cycle.
- Latency: a request sampled in IDLE at edge k is served from cycle k+1. Minimum access is 2 cycles (one IDLE cycle plus one ACCESS cycle).
  - Back-to-back requests always pass through one IDLE cycle.
- Request dropped mid-serve (granted channel's enables all 0):
  - RAM enables deassert that same cycle.
  - Next state IDLE; no completion; dstreak unchanged.
- Timeout counter:
  - Cleared on entry to a serve state.
  - Increments each serve cycle without ACCESS.
  - When count reaches TIMEOUT-1 without ACCESS, next state ERR.
- ramstate==ERROR in a serve state: next state ERR.
- ERR:
  - One cycle; RAM enables 0; both waits 1; arb_err set.
  - Next state IDLE, so the request is retried.
  - arb_err is sticky until reset.
- ramstate FREE/BUSY in a serve state: hold state; enables stay asserted.
- Inputs must be held stable by the requester until its wait deasserts.
- Reset mid-access: RAM enables drop immediately (asynchronously); the access is lost; the requester re-issues.

Decomposition:
- In cpu_types_pkg: word_t, ramstate_t (already shared) and new arb_state_t {IDLE, DSERV, ISERV, ERR}.
- One sub-module is natural: arb_timeout_counter. It holds the parameterised TIMEOUT count with clear/enable inputs and an expired output.

Test Plan:
- Reset, then a single iREN to 0x00000040; RAM returns ACCESS on the 3rd serve cycle with ramload=0x8C010004.
  - Required: ISERV for 3 cycles, iwait=0 only in the 3rd cycle, iload=0x8C010004.
- iREN and dREN asserted together (daddr=0x100).
  - Required: DSERV granted first, dwait completes, then one IDLE cycle, then ISERV. iwait stays 1 throughout the data access.
- dREN=dWEN=1, dstore=0xDEADBEEF, daddr=0x200.
  - Required: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dload=0 at completion.
- Continuous data requests with iREN held and STARVE_LIMIT=4.
  - Required: 4 data completions, then ISERV granted despite a pending data request; dstreak returns to 0.
- ramstate stuck at BUSY with TIMEOUT=8.
  - Required: ERR after 8 serve cycles, arb_err=1 sticky, IDLE next, retry issued; a later ACCESS completes normally.
- Assert nRST mid-DSERV.
  - Required: ramWEN/ramREN drop to 0 before the next edge; after release, state is IDLE, arb_err=0, both waits 1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2,
    ERR   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts stalled serve cycles; expired flags the last permitted stall cycle.
module arb_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != LAST) begin
      count <= count + W'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/memory_arbiter_fsm.sv
// Serialises instruction fetches and data accesses onto the single RAM port,
// data first, with a starvation guard that eventually forces a fetch through.
module memory_arbiter_fsm
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT      = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      arb_err
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_DSERV = DSERV;
  localparam logic [1:0] S_ISERV = ISERV;
  localparam logic [1:0] S_ERR   = ERR;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [1:0]    state, next_state;
  logic [SW-1:0] dstreak, dstreak_next;
  logic          d_req, serving, dropped, starve;
  logic          d_done, i_done, tmo_expired;

  assign d_req   = dREN | dWEN;
  assign serving = (state == S_DSERV) || (state == S_ISERV);
  assign dropped = ((state == S_DSERV) && !d_req) || ((state == S_ISERV) && !iREN);
  assign starve  = (dstreak == LIMIT) && iREN;
  assign d_done  = (state == S_DSERV) && d_req && (ramstate == ACCESS);
  assign i_done  = (state == S_ISERV) && iREN && (ramstate == ACCESS);

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (CLK),
    .rst     (nRST),
    .clr     (!serving),
    .en      (serving && (ramstate != ACCESS)),
    .expired (tmo_expired)
  );

  // NOTE: combinational blocks use blocking '=' with a default for every
  // output first, so no path leaves a signal unassigned and no latch forms.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (starve)     next_state = S_ISERV;
        else if (d_req) next_state = S_DSERV;
        else if (iREN)  next_state = S_ISERV;
      end
      S_DSERV, S_ISERV: begin
        if (dropped)                     next_state = S_IDLE;
        else if (ramstate == ERROR)      next_state = S_ERR;
        else if (ramstate == ACCESS)     next_state = S_IDLE;
        else if (tmo_expired)            next_state = S_ERR;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    dstreak_next = dstreak;
    if (d_done) begin
      if (!iREN)                 dstreak_next = '0;
      else if (dstreak != LIMIT) dstreak_next = dstreak + SW'(1);
    end else if (i_done) begin
      dstreak_next = '0;
    end
  end

  // RAM-side outputs follow the state register, so an asynchronous reset
  // drops the enables without waiting for a clock edge.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      S_DSERV: begin
        if (d_req) begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
        end
        if (d_done) begin
          dwait = 1'b0;
          dload = dWEN ? '0 : ramload;
        end
      end
      S_ISERV: begin
        if (iREN) begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
        end
        if (i_done) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state   <= S_IDLE;
      dstreak <= '0;
      arb_err <= 1'b0;
    end else begin
      state   <= next_state;
      dstreak <= dstreak_next;
      if (next_state == S_ERR) arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_arbiter_fsm.sv
// Self-checking bench: per-scenario tasks plus a load scoreboard popped on completion.
module tb_memory_arbiter_fsm;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN, arb_err;
  word_t     iload, dload, ramaddr, ramstore;

  int    total = 0;
  int    bad   = 0;
  word_t iq[$];
  word_t dq[$];
  word_t ie, de;

  localparam logic [35:0] IDLE_BUS = {1'b0, 1'b0, 1'b1, 1'b1, 32'h0};

  memory_arbiter_fsm #(.TIMEOUT(8), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: any completion must match the oldest expected load of its channel.
  always @(negedge CLK) begin
    if (nRST === 1'b0) begin
      if (iwait === 1'b0) begin
        total++;
        if (iq.size() == 0) begin
          bad++;
          $display("FAIL iload_sb: unexpected fetch completion, iload=%h", iload);
        end else begin
          ie = iq.pop_front();
          if (iload !== ie) begin
            bad++;
            $display("FAIL iload_sb: got %h want %h", iload, ie);
          end
        end
      end
      if (dwait === 1'b0) begin
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL dload_sb: unexpected data completion, dload=%h", dload);
        end else begin
          de = dq.pop_front();
          if (dload !== de) begin
            bad++;
            $display("FAIL dload_sb: got %h want %h", dload, de);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [35:0] bus();
    return {ramREN, ramWEN, iwait, dwait, ramaddr};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_bus(input string name, input logic [35:0] exp);
    @(negedge CLK);
    total++;
    if (bus() !== exp) begin
      bad++;
      $display("FAIL %s: ren/wen/iwait/dwait/addr got %h want %h", name, bus(), exp);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h44; daddr = 32'h88; dstore = 32'h1234_5678;
    ramstate = ACCESS; ramload = 32'hA5A5_A5A5;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 1100", {iwait, dwait, ramREN, ramWEN});
    end
    total++;
    if ({ramaddr, ramstore, iload, dload} !== 128'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {ramaddr, ramstore, iload, dload});
    end
    total++;
    if (arb_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_err: got %b want 0", arb_err);
    end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    ramstate = FREE; ramload = '0;
    tick();
    nRST = 1'b0;
    expect_bus("reset_release_idle", IDLE_BUS);
    tick();
  endtask

  task automatic test_ifetch();
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
    iq.push_back(32'h8C01_0004);
    expect_bus("ifetch_idle", IDLE_BUS);
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        ramstate = ACCESS; ramload = 32'h8C01_0004;
      end
      expect_bus($sformatf("ifetch_serve%0d", c), {1'b1, 1'b0, (c != 3), 1'b1, 32'h40});
      tick();
    end
    iREN = 1'b0; ramstate = FREE; ramload = '0;
    expect_bus("ifetch_after", IDLE_BUS);
    tick();
  endtask

  task automatic test_priority();
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100; ramstate = BUSY;
    dq.push_back(32'h1111_2222);
    iq.push_back(32'h3333_4444);
    expect_bus("prio_idle", IDLE_BUS);
    tick();
    for (int c = 1; c <= 2; c++) begin
      if (c == 2) begin
        ramstate = ACCESS; ramload = 32'h1111_2222;
      end
      expect_bus($sformatf("prio_dserv%0d", c), {1'b1, 1'b0, 1'b1, (c != 2), 32'h100});
      tick();
    end
    dREN = 1'b0; ramstate = BUSY; ramload = '0;
    expect_bus("prio_gap_idle", IDLE_BUS);
    tick();
    ramstate = ACCESS; ramload = 32'h3333_4444;
    expect_bus("prio_iserv", {1'b1, 1'b0, 1'b0, 1'b1, 32'h80});
    tick();
    iREN = 1'b0; ramstate = FREE; ramload = '0;
    expect_bus("prio_after", IDLE_BUS);
    tick();
  endtask

  task automatic test_write();
    dREN = 1'b1; dWEN = 1'b1; dstore = 32'hDEAD_BEEF; daddr = 32'h200;
    ramstate = ACCESS; ramload = 32'hFFFF_FFFF;
    dq.push_back(32'h0);
    expect_bus("write_idle", IDLE_BUS);
    tick();
    @(negedge CLK);
    total++;
    if ({ramREN, ramWEN, dwait, iwait, ramaddr, ramstore} !==
        {1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL write_serve: got %b %h %h want 0101 00000200 deadbeef",
               {ramREN, ramWEN, dwait, iwait}, ramaddr, ramstore);
    end
    tick();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; ramload = '0;
    expect_bus("write_after", IDLE_BUS);
    tick();
  endtask

  task automatic test_starve();
    iREN = 1'b1; iaddr = 32'hC0; dREN = 1'b1; daddr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      ramstate = BUSY;
      expect_bus($sformatf("starve_idle%0d", k), IDLE_BUS);
      tick();
      ramstate = ACCESS; ramload = 32'h5000_0000 + word_t'(k);
      dq.push_back(32'h5000_0000 + word_t'(k));
      expect_bus($sformatf("starve_dserv%0d", k), {1'b1, 1'b0, 1'b1, 1'b0, 32'h300});
      tick();
    end
    ramstate = BUSY;
    expect_bus("starve_idle4", IDLE_BUS);
    tick();
    ramstate = ACCESS; ramload = 32'h6000_00C0;
    iq.push_back(32'h6000_00C0);
    expect_bus("starve_forced_iserv", {1'b1, 1'b0, 1'b0, 1'b1, 32'hC0});
    tick();
    ramstate = BUSY;
    expect_bus("starve_reset_idle", IDLE_BUS);
    tick();
    ramstate = ACCESS; ramload = 32'h5000_0004;
    dq.push_back(32'h5000_0004);
    expect_bus("starve_data_again", {1'b1, 1'b0, 1'b1, 1'b0, 32'h300});
    tick();
    dREN = 1'b0; ramstate = BUSY;
    expect_bus("starve_idle5", IDLE_BUS);
    tick();
    ramstate = ACCESS; ramload = 32'h6000_0100;
    iq.push_back(32'h6000_0100);
    expect_bus("starve_last_iserv", {1'b1, 1'b0, 1'b0, 1'b1, 32'hC0});
    tick();
    iREN = 1'b0; ramstate = FREE; ramload = '0;
    expect_bus("starve_after", IDLE_BUS);
    tick();
  endtask

  task automatic test_drop();
    dREN = 1'b1; daddr = 32'h240; ramstate = BUSY;
    expect_bus("drop_idle", IDLE_BUS);
    tick();
    expect_bus("drop_dserv", {1'b1, 1'b0, 1'b1, 1'b1, 32'h240});
    tick();
    dREN = 1'b0; ramstate = ACCESS; ramload = 32'h9999_9999;
    expect_bus("drop_same_cycle", IDLE_BUS);
    tick();
    iREN = 1'b1; iaddr = 32'h2C0; ramstate = BUSY;
    expect_bus("drop_back_idle", IDLE_BUS);
    tick();
    expect_bus("drop_iserv", {1'b1, 1'b0, 1'b1, 1'b1, 32'h2C0});
    tick();
    iREN = 1'b0;
    expect_bus("drop_iserv_dropped", IDLE_BUS);
    tick();
    ramstate = FREE; ramload = '0;
    expect_bus("drop_after", IDLE_BUS);
    tick();
  endtask

  task automatic test_timeout();
    iREN = 1'b1; iaddr = 32'h140; ramstate = BUSY;
    expect_bus("tmo_idle", IDLE_BUS);
    tick();
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      total++;
      if ({arb_err, bus()} !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h140}) begin
        bad++;
        $display("FAIL tmo_serve%0d: err+bus got %h want %h", c, {arb_err, bus()},
                 {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h140});
      end
      tick();
    end
    @(negedge CLK);
    total++;
    if ({arb_err, bus()} !== {1'b1, IDLE_BUS}) begin
      bad++;
      $display("FAIL tmo_err_state: err+bus got %h want %h", {arb_err, bus()}, {1'b1, IDLE_BUS});
    end
    tick();
    @(negedge CLK);
    total++;
    if ({arb_err, bus()} !== {1'b1, IDLE_BUS}) begin
      bad++;
      $display("FAIL tmo_idle_after_err: err+bus got %h want %h", {arb_err, bus()}, {1'b1, IDLE_BUS});
    end
    tick();
    ramstate = ACCESS; ramload = 32'h7777_0140;
    iq.push_back(32'h7777_0140);
    expect_bus("tmo_retry", {1'b1, 1'b0, 1'b0, 1'b1, 32'h140});
    tick();
    iREN = 1'b0; ramstate = FREE; ramload = '0;
    @(negedge CLK);
    total++;
    if ({arb_err, bus()} !== {1'b1, IDLE_BUS}) begin
      bad++;
      $display("FAIL tmo_sticky: err+bus got %h want %h", {arb_err, bus()}, {1'b1, IDLE_BUS});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    dWEN = 1'b1; daddr = 32'h400; dstore = 32'h0BAD_F00D; ramstate = BUSY;
    expect_bus("rmid_idle", IDLE_BUS);
    tick();
    expect_bus("rmid_dserv", {1'b0, 1'b1, 1'b1, 1'b1, 32'h400});
    #1 nRST = 1'b1;
    #1;
    total++;
    if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'h0) begin
      bad++;
      $display("FAIL rmid_async_drop: got %b %h %h want 00 0 0", {ramREN, ramWEN}, ramaddr, ramstore);
    end
    dWEN = 1'b0; ramstate = FREE;
    @(posedge CLK);
    #1 nRST = 1'b0;
    @(negedge CLK);
    total++;
    if ({arb_err, bus()} !== {1'b0, IDLE_BUS}) begin
      bad++;
      $display("FAIL rmid_release: err+bus got %h want %h", {arb_err, bus()}, {1'b0, IDLE_BUS});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_priority();
    test_write();
    test_starve();
    test_drop();
    test_timeout();
    test_reset_mid();
    total++;
    if (iq.size() != 0 || dq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: pending fetch=%0d data=%0d want 0 0", iq.size(), dq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
